stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised multicycle stage controller for the ARM core. It steps one instruction through `N_STAGES` sequential stages, for example fetch, register fetch, execute, data memory and writeback. It drives a one-hot `stage_go` enable to each stage register. Beyond a fixed-rate stage FSM, it adds per-stage completion handshakes (multicycle memories), condition-fail stage skipping, flush, single-step debug mode, and retire/cycle/stall counters for the debug port.

## Interface
- `N_STAGES`, default 5: number of pipeline-free stages, minimum 2.
- `CNT_W`, default 32: width of each performance counter.
- `IDX_W`, default $clog2(N_STAGES): derived, not overridden.

Ports:
- `clk`  in  1  system clock.
- `nreset`  in  1  reset, synchronous, active-high.
- `run`  in  1  enables continuous sequencing; sampled only at instruction boundaries.
- `step_mode`  in  1  1 = execute one instruction per `step_req`.
- `step_req`  in  1  single-cycle pulse; starts one instruction from IDLE when `step_mode`=1.
- `stage_done`  in  N_STAGES  stage i finished its work this cycle; only bit `stage_idx` is examined.
- `skip_mask`  in  N_STAGES  stages to bypass for the current instruction. Sampled on each `stage_done` cycle; bit 0 ignored.
- `flush`  in  1  abort the current instruction and restart at stage 0.
- `stage_go`  out  N_STAGES  one-hot enable of the active stage; all zero in IDLE.
- `stage_idx`  out  IDX_W  index of the active stage.
- `busy`  out  1  state == ACTIVE.
- `retire`  out  1  one-cycle pulse: an instruction completed.
- `instr_count`  out  CNT_W  retired instructions.
- `cycle_count`  out  CNT_W  cycles spent in ACTIVE.
- `stall_count`  out  CNT_W  ACTIVE cycles with `stage_done[stage_idx]`=0.

## Operation
- **States:** IDLE, ACTIVE.
- **Reset:** state IDLE, `stage_idx`=0, `stage_go`=0, `busy`=0, `retire`=0, all counters 0.
- **Start condition:** `start = run & (~step_mode | step_req)`.
- **IDLE:**
  - `start` → ACTIVE with `stage_idx`=0.
  - Otherwise stay in IDLE.
  - `flush` is ignored.
- **ACTIVE:** `stage_go = 1 << stage_idx`, decoded from registered state. Priority, highest first:
  1. `flush`: `stage_idx`←0, remain ACTIVE, no retire, no stall count. This applies even with `stage_done` high in the same cycle.
  2. `stage_done[stage_idx]`=1: next = lowest j > `stage_idx` with `skip_mask[j]`=0.
     - If such a j exists, `stage_idx`←j.
     - If none exists (the instruction is complete): `retire`←1 next cycle and `stage_idx`←0. If `start` is also true, stay ACTIVE; otherwise go to IDLE.
  3. Otherwise it is a stall: hold state; `stall_count`++.
- `step_req` in ACTIVE is ignored. It is not queued.
- Deasserting `run` mid-instruction does not abort. The current instruction completes, then the block goes to IDLE.
- `cycle_count` increments every ACTIVE cycle.
- `instr_count` increments on the same edge that sets `retire`.
- All counters wrap modulo 2^CNT_W.

## Timing
- Start latency: `start` in IDLE cycle t → `stage_go[0]`=1 in cycle t+1.
- With `stage_done` held all-ones and `skip_mask`=0: an instruction occupies exactly `N_STAGES` cycles.
  - Back-to-back instructions have no bubble.
  - `retire` is high in the first cycle of the next instruction's stage 0.
- Each stall cycle adds one cycle of latency.
- Each skipped stage removes one cycle.
- Step mode: one instruction per `step_req`. `busy` falls in the cycle `retire` is high.
- Reset mid-instruction takes effect at the next edge; no `retire` is generated.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- The package `cpu_seq_pkg` holds:
  - the state enum (IDLE, ACTIVE);
  - the default stage index constants: IF=0, RF=1, EX=2, MEM=3, WB=4;
  - the condition-fail skip-mask constant: MEM|WB set.
- One sub-module, `seq_next_stage`: combinational search for the next unmasked stage above the current index. It outputs `next_idx` and `last` (no unmasked stage remains).
- The counters are inline in `stage_sequencer`.

## Test plan
- **Free run:** reset, `run`=1, `stage_done`=all-ones, `skip_mask`=0, N=5, 20 cycles.
  - `stage_go` cycles 00001→00010→00100→01000→10000.
  - `retire` every 5th cycle.
  - `instr_count`=3, `cycle_count`=19, `stall_count`=0.
- **Stall:** `stage_done[3]` low for 4 cycles during one instruction.
  - That instruction takes 9 cycles.
  - `stall_count`=4.
  - `stage_go`=01000 is held for 5 cycles.
- **Skip:** `skip_mask`=11000 presented at EX done.
  - Sequence is IF, RF, EX, then `retire`. The instruction takes 3 cycles.
  - `stage_go` never shows 01000 or 10000.
- **Flush with done:** `flush` and `stage_done` both high in stage 2.
  - Next `stage_idx`=0.
  - No `retire`.
  - `instr_count` is unchanged.
- **Step mode:** `step_mode`=1, `run`=1, then two `step_req` pulses 10 cycles apart, with an extra `step_req` during ACTIVE.
  - Exactly 2 retires.
  - IDLE, with `stage_go`=0, between the two instructions.
  - The extra pulse is ignored.
- **Mid-operation reset and counter wrap:**
  - `nreset` asserted in stage 3: all outputs return to their reset values and no `retire` is generated.
  - CNT_W=4 with 17 instructions: `instr_count`=1.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multicycle stage sequencer.
// Holds the sequencer state enum, default stage indices and skip masks.
package cpu_seq_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } seq_state_e;

    // Default five-stage layout
    localparam int STG_IF  = 0;
    localparam int STG_RF  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // A failed condition code suppresses the memory and writeback stages
    localparam logic [4:0] SKIP_COND_FAIL =
        (5'b1 << STG_MEM) | (5'b1 << STG_WB);

endpackage

// File: rtl/seq_next_stage.sv
// Combinational search for the lowest unmasked stage above cur_idx.
// Ports: cur_idx, skip_mask in; next_idx (valid when !last), last out.
module seq_next_stage
    import cpu_seq_pkg::*;
#(
    parameter int N_STAGES = 5,
    parameter int IDX_W    = $clog2(N_STAGES)
) (
    input  logic [IDX_W-1:0]    cur_idx,
    input  logic [N_STAGES-1:0] skip_mask,
    output logic [IDX_W-1:0]    next_idx,
    output logic                last
);

    // Scan downward so the lowest qualifying index wins
    always_comb begin
        next_idx = '0;
        last     = 1'b1;
        for (int j = N_STAGES - 1; j >= 1; j--) begin
            if (j > int'(cur_idx) && !skip_mask[j]) begin
                next_idx = IDX_W'(j);
                last     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage controller: steps one instruction through N_STAGES.
// Ports: run/step_mode/step_req start control; stage_done, skip_mask,
//        flush steer the active stage; stage_go, stage_idx, busy,
//        retire and instr/cycle/stall counters are all registered.
module stage_sequencer
    import cpu_seq_pkg::*;
#(
    parameter  int N_STAGES = 5,
    parameter  int CNT_W    = 32,
    localparam int IDX_W    = $clog2(N_STAGES)
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                run,
    input  logic                step_mode,
    input  logic                step_req,
    input  logic [N_STAGES-1:0] stage_done,
    input  logic [N_STAGES-1:0] skip_mask,
    input  logic                flush,
    output logic [N_STAGES-1:0] stage_go,
    output logic [IDX_W-1:0]    stage_idx,
    output logic                busy,
    output logic                retire,
    output logic [CNT_W-1:0]    instr_count,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    stall_count
);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] instr_q, cycle_q, stall_q;
    logic             stall;
    logic             start;
    logic             done_cur;
    logic [IDX_W-1:0] next_idx;
    logic             last;

    assign start    = run & (~step_mode | step_req);
    assign done_cur = stage_done[idx_q];

    seq_next_stage #(
        .N_STAGES (N_STAGES),
        .IDX_W    (IDX_W)
    ) u_next (
        .cur_idx   (idx_q),
        .skip_mask (skip_mask),
        .next_idx  (next_idx),
        .last      (last)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retire_d = 1'b0;
        stall    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACTIVE;
                    idx_d   = IDX_W'(STG_IF);
                end
            end
            S_ACTIVE: begin
                if (flush) begin
                    // Flush wins over a same-cycle completion
                    idx_d = IDX_W'(STG_IF);
                end else if (done_cur) begin
                    if (!last) begin
                        idx_d = next_idx;
                    end else begin
                        retire_d = 1'b1;
                        idx_d    = IDX_W'(STG_IF);
                        state_d  = start ? S_ACTIVE : S_IDLE;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            retire_q <= 1'b0;
            instr_q  <= '0;
            cycle_q  <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retire_q <= retire_d;
            if (retire_d) begin
                instr_q <= instr_q + CNT_W'(1);
            end
            if (state_q == S_ACTIVE) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (stall) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign busy        = (state_q == S_ACTIVE);
    assign stage_idx   = idx_q;
    assign stage_go    = busy ? (N_STAGES'(1) << idx_q) : '0;
    assign retire      = retire_q;
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: free run, stall, skip, flush,
// step mode, mid-instruction reset and 4-bit counter wrap.
module tb_stage_sequencer;
    import cpu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       nreset;
    logic       run;
    logic       step_mode;
    logic       step_req;
    logic [4:0] stage_done;
    logic [4:0] skip_mask;
    logic       flush;

    logic [4:0]  go;
    logic [2:0]  idx;
    logic        busy;
    logic        ret;
    logic [31:0] ic, cc, sc;

    logic [4:0]  go2;
    logic [2:0]  idx2;
    logic        busy2;
    logic        ret2;
    logic [3:0]  ic2, cc2, sc2;

    int checks   = 0;
    int failures = 0;
    int nret;

    always #5 clk = ~clk;

    stage_sequencer #(.N_STAGES(5), .CNT_W(32)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .run         (run),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .stage_done  (stage_done),
        .skip_mask   (skip_mask),
        .flush       (flush),
        .stage_go    (go),
        .stage_idx   (idx),
        .busy        (busy),
        .retire      (ret),
        .instr_count (ic),
        .cycle_count (cc),
        .stall_count (sc)
    );

    stage_sequencer #(.N_STAGES(5), .CNT_W(4)) dut4 (
        .clk         (clk),
        .nreset      (nreset),
        .run         (run),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .stage_done  (stage_done),
        .skip_mask   (skip_mask),
        .flush       (flush),
        .stage_go    (go2),
        .stage_idx   (idx2),
        .busy        (busy2),
        .retire      (ret2),
        .instr_count (ic2),
        .cycle_count (cc2),
        .stall_count (sc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        nreset     = 1'b1;
        run        = 1'b0;
        step_mode  = 1'b0;
        step_req   = 1'b0;
        stage_done = 5'b00000;
        skip_mask  = 5'b00000;
        flush      = 1'b0;
        tick();
        tick();
        chk("rst_go", 32'(go), 32'h0);
        chk("rst_idx", 32'(idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_retire", 32'(ret), 32'h0);
        chk("rst_ic", ic, 32'd0);
        chk("rst_cc", cc, 32'd0);
        chk("rst_sc", sc, 32'd0);
        nreset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);

        // Free run: edge e gives stage (e-1)%5, retire at 6,11,16
        run        = 1'b1;
        stage_done = 5'b11111;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk("free_go", 32'(go), 32'(5'b1 << ((e - 1) % 5)));
            chk("free_ret", 32'(ret),
                32'((e > 1) && ((e - 1) % 5 == 0)));
        end
        chk("free_ic", ic, 32'd3);
        chk("free_cc", cc, 32'd19);
        chk("free_sc", sc, 32'd0);

        // Stall: stage 3 held for 5 cycles, instruction takes 9
        tick();
        chk("stall_ret0", 32'(ret), 32'h1);
        chk("stall_go0", 32'(go), 32'h01);
        tick();
        tick();
        tick();
        chk("stall_go3", 32'(go), 32'h08);
        stage_done = 5'b10111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_hold", 32'(go), 32'h08);
            chk("stall_noret", 32'(ret), 32'h0);
        end
        chk("stall_sc", sc, 32'd4);
        stage_done = 5'b11111;
        tick();
        chk("stall_go4", 32'(go), 32'h10);
        tick();
        chk("stall_ret", 32'(ret), 32'h1);
        chk("stall_ic", ic, 32'd5);

        // Skip: IF, RF, EX then retire
        tick();
        chk("skip_go1", 32'(go), 32'h02);
        tick();
        chk("skip_go2", 32'(go), 32'h04);
        skip_mask = SKIP_COND_FAIL;
        tick();
        chk("skip_ret", 32'(ret), 32'h1);
        chk("skip_go0", 32'(go), 32'h01);
        chk("skip_ic", ic, 32'd6);
        skip_mask = 5'b00000;

        // Flush together with done in stage 2
        tick();
        tick();
        chk("fl_go2", 32'(go), 32'h04);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_idx", 32'(idx), 32'h0);
        chk("fl_noret", 32'(ret), 32'h0);
        chk("fl_busy", 32'(busy), 32'h1);
        chk("fl_ic", ic, 32'd6);
        chk("fl_sc", sc, 32'd4);
        chk("fl_cc", cc, 32'd35);

        // Drop run mid-instruction: it completes then idles
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stop_busy", 32'(busy), 32'h1);
        end
        tick();
        chk("stop_ret", 32'(ret), 32'h1);
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_go", 32'(go), 32'h0);
        chk("stop_ic", ic, 32'd7);

        // Step mode: pulses at edges 43 and 53, extra pulse at 45
        step_mode = 1'b1;
        run       = 1'b1;
        tick();
        chk("step_wait", 32'(busy), 32'h0);
        nret = 0;
        for (int e = 43; e <= 63; e++) begin
            step_req = (e == 43 || e == 45 || e == 53);
            tick();
            step_req = 1'b0;
            if (ret) nret++;
            if (e == 45) chk("step_extra", 32'(go), 32'h04);
            if (e == 50) begin
                chk("step_gap_go", 32'(go), 32'h0);
                chk("step_gap_busy", 32'(busy), 32'h0);
            end
            if (e == 53) chk("step_go0", 32'(go), 32'h01);
        end
        chk("step_nret", 32'(nret), 32'd2);
        chk("step_ic", ic, 32'd9);
        chk("step_end", 32'(busy), 32'h0);

        // Reset while in stage 3
        step_mode = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("mr_go3", 32'(go), 32'h08);
        nreset = 1'b1;
        tick();
        chk("mr_go", 32'(go), 32'h0);
        chk("mr_idx", 32'(idx), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_ret", 32'(ret), 32'h0);
        chk("mr_ic", ic, 32'd0);
        chk("mr_cc", cc, 32'd0);
        tick();
        chk("mr_ret2", 32'(ret), 32'h0);

        // 17 instructions: 4-bit counter wraps to 1
        nreset = 1'b0;
        for (int e = 1; e <= 86; e++) begin
            tick();
        end
        chk("wrap_ret", 32'(ret2), 32'h1);
        chk("wrap_ic4", 32'(ic2), 32'd1);
        chk("wrap_cc4", 32'(cc2), 32'd5);
        chk("wrap_ic32", ic, 32'd17);
        chk("wrap_cc32", cc, 32'd85);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
